// File: rtl/gppcu_wb_arbiter.sv
// Round-robin write-back arbiter: shares the single register-file write port
// among NREQ functional units and counts contended cycles.
module gppcu_wb_arbiter #(
  parameter int NUMREG = 32,
  parameter int DW     = 32,
  parameter int NREQ   = 3,
  parameter int CW     = 16,
  localparam int RBW   = (NUMREG > 1) ? $clog2(NUMREG) : 1
) (
  input  logic                iACLK,
  input  logic                inRST,
  input  logic [NREQ-1:0]     iREQ_VALID,
  input  logic [NREQ*RBW-1:0] iREQ_REG,
  input  logic [NREQ*DW-1:0]  iREQ_DATA,
  output logic [NREQ-1:0]     oREQ_READY,
  output logic                oWR_VALID,
  output logic [RBW-1:0]      oWR_REG,
  output logic [DW-1:0]       oWR_DATA,
  output logic [CW-1:0]       oCONFLICT_CNT
);

  localparam int PW = $clog2(NREQ);

  // Handshake: requester k transfers on a rising edge where iREQ_VALID[k] and
  // oREQ_READY[k] are both high; it must hold valid/reg/data stable until then.
  // oREQ_READY depends only on iREQ_VALID and ptr, never on the write port.

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   grantIdx;
  logic [PW-1:0]   nextPtr;
  logic            found;
  logic            contended;
  logic [NREQ-1:0] grant;
  logic [RBW-1:0]  selReg;
  logic [DW-1:0]   selData;

  // Lowest valid index overall, then overridden by the lowest valid index at
  // or above ptr: together this is a circular search starting at ptr.
  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (iREQ_VALID[k]) begin
        found    = 1'b1;
        grantIdx = PW'(k);
      end
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (iREQ_VALID[k] && (PW'(k) >= ptr)) begin
        grantIdx = PW'(k);
      end
    end
  end

  always_comb begin
    grant   = '0;
    selReg  = '0;
    selData = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (found && (grantIdx == PW'(k))) begin
        grant[k] = 1'b1;
        selReg   = iREQ_REG[k*RBW +: RBW];
        selData  = iREQ_DATA[k*DW +: DW];
      end
    end
  end

  assign nextPtr    = (grantIdx == PW'(NREQ - 1)) ? '0 : grantIdx + PW'(1);
  assign contended  = ($countones(iREQ_VALID) > 1);
  assign oREQ_READY = inRST ? grant : '0;

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      ptr           <= '0;
      oWR_VALID     <= 1'b0;
      oWR_REG       <= '0;
      oWR_DATA      <= '0;
      oCONFLICT_CNT <= '0;
    end else begin
      oWR_VALID <= found;
      if (found) begin
        oWR_REG  <= selReg;
        oWR_DATA <= selData;
        ptr      <= nextPtr;
      end
      // Saturate rather than wrap so a long-running monitor never under-reports.
      if (contended && (oCONFLICT_CNT != '1)) begin
        oCONFLICT_CNT <= oCONFLICT_CNT + CW'(1);
      end
    end
  end

endmodule

// File: doc/gppcu_wb_arbiter.md
# gppcu_wb_arbiter

Round-robin write-back arbiter that shares the single GPPCU register-file write port among NREQ functional-unit requesters (ALU, MUL, LSU). Each cycle it grants at most one request via a valid/ready handshake. The grant is registered, and the block drives the register-file write and the scoreboard release (write register / write valid) one cycle later. It also keeps a saturating count of contended cycles for performance monitoring.

## Interface
- NUMREG, 32, number of architectural registers; RBW = ceil(log2(NUMREG)), minimum 1 (5 at default)
- DW, 32, write data width
- NREQ, 3, number of requesters (2..8); index 0 = ALU, 1 = MUL, 2 = LSU at default
- CW, 16, width of contention counter
- iACLK  in  1  clock; all state updates on rising edge
- inRST  in  1  asynchronous active-low reset
- iREQ_VALID  in  NREQ  per-requester write-back request
- iREQ_REG  in  NREQ*RBW  destination register; requester k uses bits [k*RBW +: RBW]
- iREQ_DATA  in  NREQ*DW  write data; requester k uses bits [k*DW +: DW]
- oREQ_READY  out  NREQ  one-hot grant, combinational in the same cycle
- oWR_VALID  out  1  register-file write enable and scoreboard release strobe
- oWR_REG  out  RBW  register-file write address
- oWR_DATA  out  DW  register-file write data
- oCONFLICT_CNT  out  CW  saturating count of cycles with more than one valid request

## Operation
- State: grant pointer ptr (0..NREQ-1), output register {oWR_VALID, oWR_REG, oWR_DATA}, counter oCONFLICT_CNT.
- Arbitration is combinational. The grantee is the first k with iREQ_VALID[k]=1, searching ptr, ptr+1, …, NREQ-1, 0, …, ptr-1 (modulo NREQ).
- oREQ_READY[k]=1 only for the grantee. It is all zeros when no request is valid. It is never asserted to a requester whose valid is 0.
- A transfer occurs when iREQ_VALID[k] and oREQ_READY[k] are both 1. On that edge:
  - oWR_VALID←1, oWR_REG←iREQ_REG[k], oWR_DATA←iREQ_DATA[k].
  - ptr←(k+1) mod NREQ.
- With no transfer: oWR_VALID←0, and oWR_REG, oWR_DATA and ptr hold.
- The write port never back-pressures. Throughput is one write per cycle.
- Requester rules:
  - Once valid is asserted, hold valid, reg and data stable until ready is received.
  - After a transfer, the requester may present a new request in the next cycle.
- Writes to any register, including register 0, are passed through unfiltered. Filtering is the register file's responsibility.
- Counter: +1 on every cycle where popcount(iREQ_VALID) ≥ 2. It saturates at 2^CW-1 and never wraps.
- Reset (async, inRST=0): oWR_VALID=0, oWR_REG=0, oWR_DATA=0, ptr=0, oCONFLICT_CNT=0.
  - oREQ_READY is forced to all zeros while inRST=0.
  - A write in the output register when reset asserts is discarded. The scoreboard is reset by the same signal.
- Deassertion of reset is synchronised externally. The first grant is possible in the first cycle after release.

## Timing
- Request-to-ready latency: 0 cycles (combinational).
- Ready-to-oWR_VALID latency: 1 cycle. oWR_VALID is a single-cycle pulse per transfer.
- Back-to-back transfers produce oWR_VALID high on consecutive cycles.
- Fairness: a continuously valid requester is granted within NREQ cycles.
  - With all NREQ requesting continuously, grants rotate 0,1,…,NREQ-1,0,…
- Simultaneous events:
  - A requester granted at cycle t and re-requesting at t+1 has lowest priority at t+1.
  - The counter increments in the same cycle a grant is issued.
- No combinational path from oWR_* to oREQ_READY. The only combinational path is iREQ_VALID/ptr → oREQ_READY.

## Test plan
- **Reset values:** inRST=0 → all outputs 0, oREQ_READY=000. Release reset, ALU alone requests reg 5 / data 0xDEADBEEF → ready=001 that cycle, next cycle oWR_VALID=1, oWR_REG=5, oWR_DATA=0xDEADBEEF.
- **Round-robin rotation:** all three valid continuously for 6 cycles from ptr=0 → oREQ_READY sequence 001,010,100,001,010,100. oCONFLICT_CNT=6.
- **Pointer skip:** after a MUL grant (ptr=2), only ALU and MUL valid → ALU granted (LSU skipped, wrap), then MUL.
- **Hold under back-pressure:** LSU valid with reg 31 while ALU and MUL win 2 cycles → LSU inputs unchanged, granted no later than the 3rd cycle, oWR_REG=31.
- **Counter saturation:** CW=4, 20 contended cycles → oCONFLICT_CNT stops at 15.
- **Reset mid-operation:** assert inRST asynchronously between edges while oWR_VALID=1 → oWR_VALID drops immediately, ptr=0. After release, LSU+ALU valid → ALU granted first.
